// File: rtl/leaf_stream_bridge_if.sv
// Stream bundle for leaf_stream_bridge: leaf-interface valid/ack links on one side and the
// operator's AXI-stream links on the other. The master modport is the bridge's view.
interface leaf_stream_bridge_if #(
    parameter int unsigned PAYLOAD_BITS  = 32,
    parameter int unsigned NUM_IN_PORTS  = 2,
    parameter int unsigned NUM_OUT_PORTS = 1
);
    // interface -> user
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
    logic [NUM_IN_PORTS-1:0]               vld_interface2user;
    logic [NUM_IN_PORTS-1:0]               ack_user2interface;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  Input_TDATA;
    logic [NUM_IN_PORTS-1:0]               Input_TVALID;
    logic [NUM_IN_PORTS-1:0]               Input_TREADY;
    // user -> interface
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] Output_TDATA;
    logic [NUM_OUT_PORTS-1:0]              Output_TVALID;
    logic [NUM_OUT_PORTS-1:0]              Output_TREADY;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

    modport master (
        input  dout_leaf_interface2user, vld_interface2user, Input_TREADY,
        input  Output_TDATA, Output_TVALID, ack_interface2user,
        output ack_user2interface, Input_TDATA, Input_TVALID,
        output Output_TREADY, din_leaf_user2interface, vld_user2interface
    );

    modport slave (
        output dout_leaf_interface2user, vld_interface2user, Input_TREADY,
        output Output_TDATA, Output_TVALID, ack_interface2user,
        input  ack_user2interface, Input_TDATA, Input_TVALID,
        input  Output_TREADY, din_leaf_user2interface, vld_user2interface
    );
endinterface

// File: rtl/leaf_stream_bridge.sv
// Buffering bridge between leaf-interface valid/ack channels and operator AXI-stream ports, with
// an ap_start sequencer. Define LEAF_BRIDGE_STATS_EN to enable the per-channel word counters.
module leaf_stream_bridge #(
    parameter int unsigned PAYLOAD_BITS  = 32,
    parameter int unsigned NUM_IN_PORTS  = 2,
    parameter int unsigned NUM_OUT_PORTS = 1,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned START_DELAY   = 8
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         ap_start_in,
    output logic                                         ap_start_out,
    leaf_stream_bridge_if.master                         bus,
    output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*32-1:0]   word_count
);
    localparam int unsigned NumCh = NUM_IN_PORTS + NUM_OUT_PORTS;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StDelay, StRun} state_e;

    state_e     state_q;
    logic [7:0] delay_q;
    logic       start_q;
    logic       out_en_q;

    // out_en_q keeps the write-side acks low for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            delay_q  <= '0;
            start_q  <= 1'b0;
            out_en_q <= 1'b0;
        end else begin
            out_en_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (ap_start_in) begin
                        if (START_DELAY == 1) begin
                            state_q <= StRun;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= StDelay;
                            delay_q <= 8'(START_DELAY - 1);
                        end
                    end
                end
                StDelay: begin
                    delay_q <= delay_q - 8'd1;
                    if (!ap_start_in) begin
                        state_q <= StIdle;
                    end else if (delay_q == 8'd1) begin
                        state_q <= StRun;
                        start_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (!ap_start_in) begin
                        state_q <= StIdle;
                        start_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    logic run;
    logic wr_en;
    assign run          = start_q & ~reset;
    assign wr_en        = out_en_q & ~reset;
    assign ap_start_out = run;

    // Channels 0..NUM_IN_PORTS-1 are interface->user, the rest user->interface.
    logic                    wr_vld  [NumCh];
    logic                    wr_rdy  [NumCh];
    logic                    wr_fire [NumCh];
    logic [PAYLOAD_BITS-1:0] wr_data [NumCh];
    logic                    rd_vld  [NumCh];
    logic                    rd_rdy  [NumCh];
    logic                    rd_fire [NumCh];
    logic [PAYLOAD_BITS-1:0] rd_data [NumCh];
    logic [31:0]             cnt     [NumCh];

    always_comb begin
        wr_vld                       = '{default: 1'b0};
        wr_data                      = '{default: '0};
        rd_rdy                       = '{default: 1'b0};
        bus.ack_user2interface       = '0;
        bus.Input_TVALID             = '0;
        bus.Input_TDATA              = '0;
        bus.Output_TREADY            = '0;
        bus.vld_user2interface       = '0;
        bus.din_leaf_user2interface  = '0;
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            wr_vld[i]  = bus.vld_interface2user[i];
            wr_data[i] = bus.dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            rd_rdy[i]  = bus.Input_TREADY[i];
            bus.ack_user2interface[i]                          = wr_rdy[i];
            bus.Input_TVALID[i]                                = rd_vld[i];
            bus.Input_TDATA[i*PAYLOAD_BITS +: PAYLOAD_BITS]    = rd_data[i];
        end
        for (int j = 0; j < NUM_OUT_PORTS; j++) begin
            wr_vld[NUM_IN_PORTS+j]  = bus.Output_TVALID[j];
            wr_data[NUM_IN_PORTS+j] = bus.Output_TDATA[j*PAYLOAD_BITS +: PAYLOAD_BITS];
            rd_rdy[NUM_IN_PORTS+j]  = bus.ack_interface2user[j];
            bus.Output_TREADY[j]      = wr_rdy[NUM_IN_PORTS+j];
            bus.vld_user2interface[j] = rd_vld[NUM_IN_PORTS+j];
            bus.din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS] =
                rd_data[NUM_IN_PORTS+j];
        end
    end

    for (genvar k = 0; k < NumCh; k++) begin : g_ch
        localparam bit IsIn = (k < NUM_IN_PORTS);

        logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
        logic [AW:0]             wr_ptr_q;
        logic [AW:0]             rd_ptr_q;
        logic                    full;
        logic                    empty;

        assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        assign empty = (wr_ptr_q == rd_ptr_q);

        // Input FIFOs fill in any state but only present to the operator in RUN;
        // output FIFOs accept from the operator only in RUN but always drain.
        assign wr_rdy[k]  = ~full & wr_en & (IsIn | run);
        assign rd_vld[k]  = ~empty & ~reset & (~IsIn | run);
        assign wr_fire[k] = wr_vld[k] & wr_rdy[k];
        assign rd_fire[k] = rd_vld[k] & rd_rdy[k];
        assign rd_data[k] = mem_q[rd_ptr_q[AW-1:0]];

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_fire[k]) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
                if (rd_fire[k]) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end

        always_ff @(posedge clk) begin
            if (wr_fire[k]) mem_q[wr_ptr_q[AW-1:0]] <= wr_data[k];
        end

`ifdef LEAF_BRIDGE_STATS_EN
        logic [31:0] cnt_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (wr_fire[k]) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
        assign cnt[k] = cnt_q & {32{~reset}};
`else
        assign cnt[k] = '0;
`endif
    end

`ifdef LEAF_BRIDGE_STATS_EN
    always_comb begin
        word_count = '0;
        for (int k = 0; k < NumCh; k++) begin
            word_count[k*32 +: 32] = cnt[k];
        end
    end
`else
    assign word_count = '0;
`endif
endmodule
